fb_scanout: RTL and testbench
=============================

# fb_scanout

Frame-buffer scan-out reader for the DPA device. It reads a FB_W×FB_H frame out of the shared image memory, starting at a latched base address, and streams pixels in raster order to the display side over a valid/ready interface with line and frame markers. It sits on the read side of the same image memory that the photo/time controller writes. It reaches that memory through a request/grant port arbitrated at top level.

## Interface
Parameters:
- ADDR_W, 20, image-memory address width
- PIX_W, 24, pixel width (RGB888)
- FB_W, 256, frame width in pixels (power of two)
- FB_H, 256, frame height in lines (power of two)
- FIFO_DEPTH, 4, pixel buffer depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; ignored while busy
- fb_base  in  ADDR_W  frame base address, sampled on an accepted start
- busy  out  1  high from the cycle after an accepted start until the last pixel is accepted
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address, valid while mem_req is high
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  PIX_W  read data
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts the pixel
- pix_data  out  PIX_W  pixel value
- pix_sol / pix_eol  out  1  first / last pixel of a line
- pix_sof / pix_eof  out  1  first / last pixel of a frame

## Operation
- FSM states:
  - IDLE → FETCH on start.
  - FETCH → DRAIN when the last request (x=FB_W-1, y=FB_H-1) is granted.
  - DRAIN → IDLE when the FIFO is empty, no read is outstanding, and the last pixel is accepted.
- Request counters rx, ry: step on mem_gnt, with rx wrapping to 0 and ry incrementing.
- mem_addr = base_q + ry*FB_W + rx, truncated modulo 2^ADDR_W; wrap-around past the top of memory is legal.
- Credit rule: mem_req = (state==FETCH) && (fifo_count + outstanding < FIFO_DEPTH). outstanding is 0 or 1. Overflow is impossible by construction.
- mem_rvalid writes mem_rdata into the FIFO. mem_rvalid is ignored in IDLE.
- Output counters ox, oy: step on pix_valid && pix_ready. The markers are decoded from ox/oy combinationally: sol=(ox==0), eol=(ox==FB_W-1), sof=sol&&(oy==0), eof=eol&&(oy==FB_H-1).
- Downstream stall (pix_ready low): pix_data and the markers hold; fetching continues until credits are exhausted.
- start during busy: ignored; base_q is unchanged.
- Reset values: every output is 0 (busy, mem_req, mem_addr, pix_valid, pix_data, all markers). State is IDLE, counters are 0, the FIFO is empty, outstanding is 0.
- Reset mid-frame: abort immediately. Any mem_rvalid arriving after reset is discarded.

## Timing
- Memory read latency is fixed at 1: a grant in cycle T implies mem_rvalid and mem_rdata in T+1.
- mem_addr and mem_req are registered outputs; they hold until granted.
- FIFO is first-word-fall-through with a registered head. Data written at the end of cycle T appears as pix_valid in T+1.
- With start in T0 and mem_gnt tied high:
  - busy and mem_req rise in T1.
  - rvalid occurs in T2.
  - First pix_valid (sof=1) occurs in T3.
- Sustained throughput is 1 pixel/cycle with gnt and ready held high.
- Last-pixel handshake in cycle T: busy=0 in T+1. A start may be accepted in T+1.
- A simultaneous FIFO read and write in one cycle keeps the count unchanged.

## Structure
- Shared package dpa_pkg:
  - ADDR_W, PIX_W, FB_W, FB_H defaults
  - FSM state enum (IDLE, FETCH, DRAIN)
  - the pixel-marker struct
- Sub-module scanout_fifo: synchronous first-word-fall-through FIFO with parameters PIX_W and FIFO_DEPTH. Ports: wr_en, wr_data, rd_en, rd_data, count, empty. It is reused by the time-overlay path.
- Top level holds the FSM, the request counters, credit logic and the output counters.

## Test plan
- Reset, then fb_base=20'h10000, start, gnt=1, ready=1 → 65536 pixels in consecutive cycles with addresses 0x10000..0x1FFFF; sof on pixel 0, eof on pixel 65535; busy low one cycle later.
- fb_base=20'hFFFF0 → mem_addr wraps 0xFFFFF→0x00000 at pixel 16; data order is preserved.
- ready low for 20 cycles mid-line → at most FIFO_DEPTH reads issued; pix_data held stable; no pixel lost or duplicated; eol lands on x=255.
- Random mem_gnt (50%) and random ready → scoreboard matches the memory model, the marker pattern matches per line, and the FIFO never overflows.
- start pulsed while busy with a different fb_base → ignored; the frame completes from the original base.
- Reset asserted in FETCH with one read outstanding → all outputs 0 next cycle; the late mem_rvalid is discarded; a following start produces a clean frame beginning with sof.

Source files
------------

// File: rtl/dpa_pkg.sv
// dpa_pkg: shared definitions for the DPA image-memory blocks.
// Holds the default frame geometry and bus widths, the scan-out FSM state
// encoding and the per-pixel line/frame marker bundle.
package dpa_pkg;

  localparam int DPA_ADDR_W = 20;   // image-memory address width
  localparam int DPA_PIX_W  = 24;   // RGB888 pixel
  localparam int DPA_FB_W   = 256;  // frame width in pixels
  localparam int DPA_FB_H   = 256;  // frame height in lines

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } pix_mark_t;

endpackage

// File: rtl/scanout_fifo.sv
// scanout_fifo: synchronous first-word-fall-through pixel FIFO.
// The head entry is always presented on rd_data straight from the storage
// registers, so a word written at the end of cycle T is visible in T+1.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   wr_en, wr_data  push one word (dropped only if full with no pop)
//   rd_en           pop the head word (ignored when empty)
//   rd_data         current head word
//   count           number of stored words
//   empty           no word stored
module scanout_fifo #(
  parameter int PIX_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [PIX_W-1:0]                wr_data,
  input  logic                            rd_en,
  output logic [PIX_W-1:0]                rd_data,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == CW'(0));
  assign rd_data = mem[rd_ptr];
  assign do_rd   = rd_en && !empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_wr   = wr_en && ((count < CW'(FIFO_DEPTH)) || do_rd);

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1'b1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: reads one FB_W x FB_H frame from image memory starting at a
// base address latched on start, and streams the pixels in raster order over
// a valid/ready port with line and frame markers.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, fb_base             begin a frame at fb_base (ignored while busy)
//   busy                       frame in progress
//   mem_req, mem_addr, mem_gnt request/grant read port (registered request)
//   mem_rvalid, mem_rdata      read return, one cycle after the grant
//   pix_valid, pix_ready       downstream handshake
//   pix_data                   pixel value
//   pix_sol/eol/sof/eof        first/last pixel of line/frame
module fb_scanout #(
  parameter int ADDR_W     = dpa_pkg::DPA_ADDR_W,
  parameter int PIX_W      = dpa_pkg::DPA_PIX_W,
  parameter int FB_W       = dpa_pkg::DPA_FB_W,
  parameter int FB_H       = dpa_pkg::DPA_FB_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof
);

  import dpa_pkg::*;

  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(FB_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FB_H - 1);

  scan_state_e       state, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [XW-1:0]     rx, rx_nxt, ox, ox_nxt;
  logic [YW-1:0]     ry, ry_nxt, oy, oy_nxt;
  logic              outstanding;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CW-1:0]     fifo_count, count_nxt;
  logic              fifo_empty;
  logic              grant, start_ok, last_req, fire, wr_en, drain_done;
  pix_mark_t         mark;

  assign grant     = mem_req && mem_gnt;
  assign start_ok  = start && (state == IDLE);
  assign last_req  = (rx == X_LAST) && (ry == Y_LAST);
  assign pix_valid = !fifo_empty;
  assign fire      = pix_valid && pix_ready;
  // Returns are only meaningful inside a frame; anything arriving while idle
  // (e.g. a read granted just before a reset) is dropped.
  assign wr_en     = mem_rvalid && (state != IDLE);
  assign drain_done = fire && mark.eof && !outstanding
                      && (fifo_count == CW'(1)) && !wr_en;

  scanout_fifo #(
    .PIX_W      (PIX_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (mem_rdata),
    .rd_en   (fire),
    .rd_data (pix_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // Markers decode the output position; they are forced low with no pixel shown.
  always_comb begin
    mark = '0;
    if (pix_valid) begin
      mark.sol = (ox == '0);
      mark.eol = (ox == X_LAST);
      mark.sof = (ox == '0) && (oy == '0);
      mark.eof = (ox == X_LAST) && (oy == Y_LAST);
    end else begin
      mark = '0;
    end
  end

  assign pix_sol = mark.sol;
  assign pix_eol = mark.eol;
  assign pix_sof = mark.sof;
  assign pix_eof = mark.eof;

  // Next-state, counter stepping, credit check and next request address.
  always_comb begin
    state_nxt = state;
    base_nxt  = base_q;
    rx_nxt    = rx;
    ry_nxt    = ry;
    ox_nxt    = ox;
    oy_nxt    = oy;

    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
        else       state_nxt = IDLE;
      end
      FETCH: begin
        if (grant && last_req) state_nxt = DRAIN;
        else                   state_nxt = FETCH;
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
        else            state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase

    if (start_ok) begin
      base_nxt = fb_base;
      rx_nxt   = '0;
      ry_nxt   = '0;
      ox_nxt   = '0;
      oy_nxt   = '0;
    end else begin
      if (grant) begin
        rx_nxt = rx + XW'(1'b1);
        if (rx == X_LAST) ry_nxt = ry + YW'(1'b1);
        else              ry_nxt = ry;
      end else begin
        rx_nxt = rx;
        ry_nxt = ry;
      end
      if (fire) begin
        ox_nxt = ox + XW'(1'b1);
        if (ox == X_LAST) oy_nxt = oy + YW'(1'b1);
        else              oy_nxt = oy;
      end else begin
        ox_nxt = ox;
        oy_nxt = oy;
      end
    end

    // Credits are evaluated on next-cycle occupancy so the registered request
    // never asks for more than the FIFO can absorb.
    count_nxt = fifo_count + CW'(wr_en) - CW'(fire);
    req_nxt   = (state_nxt == FETCH) && ((count_nxt + CW'(grant)) < CW'(FIFO_DEPTH));
    // FB_W is a power of two, so {ry,rx} is ry*FB_W+rx; the add wraps at 2^ADDR_W.
    addr_nxt  = base_nxt + ADDR_W'({ry_nxt, rx_nxt});
  end

  // State, counters and the registered request/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      rx          <= '0;
      ry          <= '0;
      ox          <= '0;
      oy          <= '0;
      outstanding <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      base_q      <= base_nxt;
      rx          <= rx_nxt;
      ry          <= ry_nxt;
      ox          <= ox_nxt;
      oy          <= oy_nxt;
      outstanding <= grant;
      mem_req     <= req_nxt;
      mem_addr    <= addr_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: randomized self-checking bench for fb_scanout.
// A reduced 32x16 frame keeps every scenario short. The memory model returns
// a hash of the address one cycle after each grant; expected pixels, markers
// and addresses come from the raster index of each pixel.
module tb_fb_scanout;

  localparam int AW = 20;
  localparam int PW = 24;
  localparam int W  = 32;
  localparam int H  = 16;
  localparam int D  = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] fb_base = '0;
  logic          busy, mem_req, mem_gnt, mem_rvalid, pix_valid, pix_ready;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rdata, pix_data;
  logic          pix_sol, pix_eol, pix_sof, pix_eof;

  int vectors = 0;
  int miscompares = 0;

  // bench configuration
  bit            gnt_random = 1'b0;
  bit            ready_random = 1'b0;
  int            stall_at = 0;
  int            stall_len = 0;
  int            restart_at = -1;
  logic [AW-1:0] restart_base = '0;

  // captured frame
  logic [PW-1:0] got_data[$];
  logic [3:0]    got_mark[$];
  int            got_cyc[$];
  logic [AW-1:0] got_addr[$];
  int            busy_fall, stall_grants, hold_err, max_inflight;
  bit            first_busy, first_req, timed_out;

  fb_scanout #(
    .ADDR_W(AW), .PIX_W(PW), .FB_W(W), .FB_H(H), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fb_base(fb_base), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mem_model(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {12'h000, a} * 32'h9E37_79B1;
    return t[31:8] ^ {4'h0, a};
  endfunction

  // {sol, eol, sof, eof} for the i-th pixel of a frame in raster order
  function automatic logic [3:0] exp_mark(input int i);
    int x, y;
    x = i % W;
    y = i / W;
    return {x == 0, x == W - 1, (x == 0) && (y == 0), (x == W - 1) && (y == H - 1)};
  endfunction

  // Memory: a grant seen in cycle T returns data in T+1; gnt changes after each edge.
  initial begin : responder
    logic          p;
    logic [AW-1:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_gnt    = 1'b1;
    forever begin
      @(negedge clk);
      p = mem_req && mem_gnt;
      a = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = p;
      mem_rdata  = p ? mem_model(a) : PW'($urandom);
      mem_gnt    = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    fb_base = '0;
    pix_ready = 1'b1;
    gnt_random = 1'b0;
    ready_random = 1'b0;
    stall_len = 0;
    restart_at = -1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Start is high for exactly one cycle (T0); returns just after the T1 edge.
  task automatic pulse_start(input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    start = 1'b1;
    fb_base = base;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one frame from T1 until busy drops (or the budget expires), recording
  // accepted pixels, granted addresses and handshake statistics.
  task automatic collect(input int budget);
    int            cyc, inflight;
    bit            stalled, in_stall;
    logic [PW-1:0] pd;
    logic [3:0]    pm;
    got_data.delete(); got_mark.delete(); got_cyc.delete(); got_addr.delete();
    busy_fall = -1; stall_grants = 0; hold_err = 0; max_inflight = 0;
    timed_out = 1'b0; inflight = 0; stalled = 1'b0; pd = '0; pm = '0;
    cyc = 1;
    while (1) begin
      in_stall = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      if (in_stall)          pix_ready = 1'b0;
      else if (ready_random) pix_ready = 1'($urandom_range(0, 1));
      else                   pix_ready = 1'b1;
      start = (cyc == restart_at);
      if (cyc == restart_at) fb_base = restart_base;
      @(negedge clk);
      if (cyc == 1) begin
        first_busy = busy;
        first_req  = mem_req;
      end
      if (stalled && (!pix_valid || pix_data !== pd ||
                      {pix_sol, pix_eol, pix_sof, pix_eof} !== pm)) hold_err++;
      if (mem_req && mem_gnt) begin
        got_addr.push_back(mem_addr);
        inflight++;
        if (in_stall) stall_grants++;
      end
      if (pix_valid && pix_ready) begin
        got_data.push_back(pix_data);
        got_mark.push_back({pix_sol, pix_eol, pix_sof, pix_eof});
        got_cyc.push_back(cyc);
        inflight--;
      end
      if (inflight > max_inflight) max_inflight = inflight;
      stalled = pix_valid && !pix_ready;
      pd = pix_data;
      pm = {pix_sol, pix_eol, pix_sof, pix_eof};
      if (!busy && cyc > 1) begin
        busy_fall = cyc;
        break;
      end
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, mem_req, pix_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/req/valid=%b expected 000", {busy, mem_req, pix_valid});
    end
    vectors++;
    if (mem_addr !== 20'h00000) begin
      miscompares++;
      $display("FAIL reset_addr: got %h expected 00000", mem_addr);
    end
    vectors++;
    if (pix_data !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 000000", pix_data);
    end
    vectors++;
    if ({pix_sol, pix_eol, pix_sof, pix_eof} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_marks: got %b expected 0000", {pix_sol, pix_eol, pix_sof, pix_eof});
    end
    do_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, mem_req, pix_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy/req/valid=%b expected 000", {busy, mem_req, pix_valid});
    end
  endtask

  task automatic test_full_frame();
    logic [AW-1:0] base;
    do_reset();
    base = 20'h10000;
    pulse_start(base);
    collect(N + 100);
    vectors++;
    if ({first_busy, first_req} !== 2'b11) begin
      miscompares++;
      $display("FAIL t1_busy_req: got %b expected 11", {first_busy, first_req});
    end
    vectors++;
    if (timed_out || got_data.size() != N || got_addr.size() != N) begin
      miscompares++;
      $display("FAIL full_count: pixels %0d addrs %0d timeout %0d expected %0d", got_data.size(), got_addr.size(), timed_out, N);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== mem_model(base + AW'(i)) || got_mark[i] !== exp_mark(i) || got_cyc[i] != 3 + i) begin
        miscompares++;
        $display("FAIL full_pix[%0d]: data %h marks %b cyc %0d expected %h %b %0d", i, got_data[i], got_mark[i], got_cyc[i], mem_model(base + AW'(i)), exp_mark(i), 3 + i);
      end
    end
    for (int i = 0; i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== base + AW'(i)) begin
        miscompares++;
        $display("FAIL full_addr[%0d]: got %h expected %h", i, got_addr[i], base + AW'(i));
      end
    end
    vectors++;
    if (busy_fall != N + 3) begin
      miscompares++;
      $display("FAIL busy_fall: cycle %0d expected %0d", busy_fall, N + 3);
    end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] base;
    do_reset();
    base = 20'hFFFF0;
    pulse_start(base);
    collect(N + 100);
    vectors++;
    if (got_addr.size() != N || got_addr[15] !== 20'hFFFFF || got_addr[16] !== 20'h00000) begin
      miscompares++;
      $display("FAIL wrap_point: n %0d a15 %h a16 %h expected %0d FFFFF 00000", got_addr.size(), got_addr[15], got_addr[16], N);
    end
    vectors++;
    if (got_data.size() != N) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d expected %0d", got_data.size(), N);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== mem_model(base + AW'(i)) || got_mark[i] !== exp_mark(i)) begin
        miscompares++;
        $display("FAIL wrap_pix[%0d]: data %h marks %b expected %h %b", i, got_data[i], got_mark[i], mem_model(base + AW'(i)), exp_mark(i));
      end
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] base;
    do_reset();
    base = 20'h05000;
    stall_at = 10;
    stall_len = 20;
    pulse_start(base);
    collect(N + 200);
    vectors++;
    if (stall_grants > D) begin
      miscompares++;
      $display("FAIL stall_reads: got %0d reads during stall, expected at most %0d", stall_grants, D);
    end
    vectors++;
    if (hold_err != 0) begin
      miscompares++;
      $display("FAIL stall_hold: %0d unstable cycles expected 0", hold_err);
    end
    vectors++;
    if (got_data.size() != N || timed_out) begin
      miscompares++;
      $display("FAIL stall_count: got %0d timeout %0d expected %0d", got_data.size(), timed_out, N);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== mem_model(base + AW'(i)) || got_mark[i] !== exp_mark(i)) begin
        miscompares++;
        $display("FAIL stall_pix[%0d]: data %h marks %b expected %h %b", i, got_data[i], got_mark[i], mem_model(base + AW'(i)), exp_mark(i));
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    for (int f = 0; f < 2; f++) begin
      do_reset();
      gnt_random = 1'b1;
      ready_random = 1'b1;
      base = AW'($urandom);
      pulse_start(base);
      collect(20 * N);
      vectors++;
      if (got_data.size() != N || got_addr.size() != N || timed_out) begin
        miscompares++;
        $display("FAIL rand_count[%0d]: pixels %0d addrs %0d timeout %0d expected %0d", f, got_data.size(), got_addr.size(), timed_out, N);
      end
      vectors++;
      if (max_inflight > D) begin
        miscompares++;
        $display("FAIL rand_credit[%0d]: in flight %0d expected at most %0d", f, max_inflight, D);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        vectors++;
        if (got_data[i] !== mem_model(base + AW'(i)) || got_mark[i] !== exp_mark(i) || got_addr[i] !== base + AW'(i)) begin
          miscompares++;
          $display("FAIL rand_pix[%0d]: data %h marks %b addr %h expected %h %b %h", i, got_data[i], got_mark[i], got_addr[i], mem_model(base + AW'(i)), exp_mark(i), base + AW'(i));
        end
      end
    end
  endtask

  task automatic test_start_busy();
    logic [AW-1:0] base;
    do_reset();
    base = 20'h20000;
    restart_at = 40;
    restart_base = 20'h30000;
    pulse_start(base);
    collect(N + 100);
    vectors++;
    if (got_data.size() != N || busy_fall != N + 3) begin
      miscompares++;
      $display("FAIL restart_len: pixels %0d busy_fall %0d expected %0d %0d", got_data.size(), busy_fall, N, N + 3);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== mem_model(base + AW'(i))) begin
        miscompares++;
        $display("FAIL restart_pix[%0d]: data %h expected %h", i, got_data[i], mem_model(base + AW'(i)));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] base;
    bit            seen;
    do_reset();
    pulse_start(20'h00040);
    repeat (5) @(posedge clk);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = mem_req && mem_gnt;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL mid_grant: no grant seen, expected one in FETCH");
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, mem_req, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof} !== 7'b0 || mem_addr !== 20'h00000 || pix_data !== 24'h000000) begin
      miscompares++;
      $display("FAIL mid_reset_outs: ctrl %b addr %h data %h expected all zero", {busy, mem_req, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof}, mem_addr, pix_data);
    end
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL late_rvalid: pix_valid %b expected 0", pix_valid);
    end
    base = 20'h00100;
    pulse_start(base);
    collect(N + 100);
    vectors++;
    if (got_data.size() != N || got_mark[0] !== 4'b1010) begin
      miscompares++;
      $display("FAIL clean_frame: pixels %0d first marks %b expected %0d 1010", got_data.size(), got_mark[0], N);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== mem_model(base + AW'(i)) || got_mark[i] !== exp_mark(i)) begin
        miscompares++;
        $display("FAIL clean_pix[%0d]: data %h marks %b expected %h %b", i, got_data[i], got_mark[i], mem_model(base + AW'(i)), exp_mark(i));
      end
    end
  endtask

  initial begin
    pix_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_addr_wrap();
    test_stall();
    test_random();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
